// File: rtl/jk_mod_counter.sv
// Modulo-MOD up/down counter built on a bank of JK flip-flops, exposing the J/K excitation.
// Define JK_MOD_COUNTER_SAT_EN to saturate at 0 / MOD-1 instead of wrapping.
module jk_mod_counter #(
    parameter int WIDTH      = 4,
    parameter int MOD        = 10,
    parameter int PRESET_VAL = 0
) (
    input  logic             clk,
    input  logic             preset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             wrap
);

    // One extra bit so MOD == 2**WIDTH is representable in comparisons.
    localparam logic [WIDTH:0]   MOD_W    = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MOD - 1);
    localparam logic [WIDTH-1:0] PRE_VAL  = WIDTH'(PRESET_VAL);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] next_val;
    logic             at_max, at_zero, illegal;

    assign at_max  = (q_q == MAX_VAL);
    assign at_zero = (q_q == '0);
    assign illegal = ({1'b0, q_q} >= MOD_W);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        next_val = q_q;
        if (load) begin
            next_val = ({1'b0, din} < MOD_W) ? din : MAX_VAL;
        end else if (en) begin
            if (illegal) begin
                next_val = '0;
            end else if (up) begin
`ifdef JK_MOD_COUNTER_SAT_EN
                next_val = at_max ? MAX_VAL : q_q + 1'b1;
`else
                next_val = at_max ? '0 : q_q + 1'b1;
`endif
            end else begin
`ifdef JK_MOD_COUNTER_SAT_EN
                next_val = at_zero ? '0 : q_q - 1'b1;
`else
                next_val = at_zero ? MAX_VAL : q_q - 1'b1;
`endif
            end
        end
    end

    // Set only rising bits, clear only falling bits; J=K=1 cannot occur.
    assign j_vec = next_val & ~q_q;
    assign k_vec = q_q & ~next_val;

    always_comb begin
        q_d = (q_q & ~k_vec) | (~q_q & j_vec);
    end

    assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

    // NOTE: sequential state uses non-blocking assignments; preset is asynchronous and active-high.
    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            q_q <= PRE_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

`ifdef JK_MOD_COUNTER_SAT_EN
    assign wrap = 1'b0;
`else
    logic wrap_q, wrap_d;

    always_comb begin
        wrap_d = tc;
    end

    always_ff @(posedge clk or posedge preset) begin
        if (preset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;
`endif

endmodule
